mem_port_arbiter: RTL and testbench

//  Shares one single-port instruction/data memory bus between the IF stage (fetch) and the MEM stage (load/store).
//  One transaction is outstanding at a time. MEM stage has priority, with a bounded-streak guarantee for fetch.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_pick.sv | 17 +
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default limits for the IF/MEM memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  localparam int unsigned MAX_DSTREAK_DEF = 4;
  localparam int unsigned TIMEOUT_DEF     = 64;

endpackage

// File: rtl/arb_pick.sv
// Priority policy: MEM stage first, unless fetch has waited out a full
// streak of data grants.
module arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic streak_sat,
  output logic grant_if,
  output logic grant_dm
);

  // Data wins unless fetch is pending and the streak is exhausted.
  always_comb begin
    grant_dm = dm_req && !(if_req && streak_sat);
    grant_if = if_req && !grant_dm;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between fetch and load/store,
// with fetch anti-starvation and a response watchdog.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            err_timeout,
  output logic            err_spurious
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t   state;
  arb_owner_t   owner;
  logic [SW-1:0] streak;
  logic [WW-1:0] wdog;

  logic grant_if;
  logic grant_dm;
  logic streak_sat;
  logic to_hit;
  logic resp;
  logic [DW-1:0] rdata_mux;

  assign streak_sat = (streak == SW'(MAX_DSTREAK));

  arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .streak_sat (streak_sat),
    .grant_if   (grant_if),
    .grant_dm   (grant_dm)
  );

  // Response routing; a reset cycle suppresses every pulse.
  always_comb begin
    to_hit = (state == WAIT) && !mem_rvalid
             && (wdog == WW'(TIMEOUT - 1));
    resp = !reset && (state == WAIT)
           && (mem_rvalid || to_hit);
    rdata_mux = (mem_rvalid && !mem_we) ? mem_rdata : '0;
    if_rvalid = resp && (owner == OWN_IF);
    dm_rvalid = resp && (owner == OWN_DM);
    if_rdata = if_rvalid ? rdata_mux : '0;
    dm_rdata = dm_rvalid ? rdata_mux : '0;
    stall_if = if_req && !if_rvalid;
    stall_mem = dm_req && !dm_rvalid;
    err_timeout = !reset && to_hit;
    err_spurious = !reset && mem_rvalid
                   && (state != WAIT);
  end

  // FSM, field latch, streak and watchdog counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= NONE;
      streak    <= '0;
      wdog      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_dm) begin
            state     <= ISSUE;
            owner     <= OWN_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req)
              streak <= '0;
            else if (!streak_sat)
              streak <= streak + SW'(1);
          end else if (grant_if) begin
            state     <= ISSUE;
            owner     <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= '1;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
            wdog    <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid || to_hit) begin
            state <= IDLE;
            owner <= NONE;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: begin
          state <= IDLE;
          owner <= NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Cycle Tn is the interval following rising edge n.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_if;
  logic        stall_mem;
  logic        err_timeout;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(32), .DW(32),
    .MAX_DSTREAK(4), .TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_be        (dm_be),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] exp_g [6];
    exp_g = '{32'h3000, 32'h3000, 32'h3000,
              32'h3000, 32'h0300, 32'h3000};

    // Reset state
    tick; tick;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_err_sp", err_spurious, 0);
    reset = 1'b0;
    tick;

    // 1: single fetch, minimum latency
    if_req = 1; if_addr = 32'h100;
    #1;
    chk("t1_stall_T0", stall_if, 1);
    chk("t1_req_T0", mem_req, 0);
    tick;
    chk("t1_req_T1", mem_req, 1);
    chk("t1_addr_T1", mem_addr, 32'h100);
    chk("t1_we_T1", mem_we, 0);
    chk("t1_stall_T1", stall_if, 1);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    #1;
    chk("t1_req_T2", mem_req, 0);
    chk("t1_rvalid_T2", if_rvalid, 1);
    chk("t1_rdata_T2", if_rdata, 32'h00500093);
    chk("t1_stall_T2", stall_if, 0);
    chk("t1_dmrv_T2", dm_rvalid, 0);
    tick;
    mem_rvalid = 0; mem_rdata = '0; if_req = 0;
    #1;
    chk("t1_rvalid_T3", if_rvalid, 0);
    chk("t1_rdata_T3", if_rdata, 0);
    tick;
    chk("t1_idle_req", mem_req, 0);

    // 2: collision, data first then fetch
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    tick;
    chk("t2_addr_T1", mem_addr, 32'h2000);
    chk("t2_stall_T1", stall_if, 1);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h11112222;
    #1;
    chk("t2_dmrv_T2", dm_rvalid, 1);
    chk("t2_dmrd_T2", dm_rdata, 32'h11112222);
    chk("t2_ifrv_T2", if_rvalid, 0);
    chk("t2_ifrd_T2", if_rdata, 0);
    chk("t2_stall_T2", stall_if, 1);
    tick;
    mem_rvalid = 0; dm_req = 0;
    #1;
    chk("t2_req_T3", mem_req, 0);
    chk("t2_stall_T3", stall_if, 1);
    tick;
    chk("t2_req_T4", mem_req, 1);
    chk("t2_addr_T4", mem_addr, 32'h200);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h33334444;
    #1;
    chk("t2_ifrv_T5", if_rvalid, 1);
    chk("t2_ifrd_T5", if_rdata, 32'h33334444);
    tick;
    mem_rvalid = 0; if_req = 0;
    tick;

    // 3: starvation bound, DM x4 then IF then DM
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_addr = 32'h3000;
    for (int g = 0; g < 6; g++) begin
      int n;
      n = 0;
      while (!mem_req && n < 5) begin
        tick;
        n++;
      end
      chk($sformatf("t3_req%0d", g), mem_req, 1);
      chk($sformatf("t3_grant%0d", g),
          mem_addr, exp_g[g]);
      mem_gnt = 1;
      tick;
      mem_gnt = 0;
      mem_rvalid = 1; mem_rdata = 32'h0;
      #1;
      chk($sformatf("t3_rv%0d", g),
          {if_rvalid, dm_rvalid},
          (g == 4) ? 2'b10 : 2'b01);
      tick;
      mem_rvalid = 0;
      if (g == 4) if_req = 0;
      if (g == 5) dm_req = 0;
    end
    tick;
    chk("t3_idle", mem_req, 0);

    // 4: store ack with delayed grant
    dm_req = 1; dm_we = 1; dm_be = 4'b0011;
    dm_addr = 32'h4000; dm_wdata = 32'hDEADBEEF;
    tick;
    chk("t4_req", mem_req, 1);
    chk("t4_we", mem_we, 1);
    chk("t4_be", mem_be, 4'b0011);
    chk("t4_wdata", mem_wdata, 32'hDEADBEEF);
    dm_wdata = 32'h0; dm_be = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("t4_hold_req%0d", c), mem_req, 1);
      chk($sformatf("t4_hold_be%0d", c),
          mem_be, 4'b0011);
      chk($sformatf("t4_hold_wd%0d", c),
          mem_wdata, 32'hDEADBEEF);
    end
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    #1;
    chk("t4_dmrv", dm_rvalid, 1);
    chk("t4_dmrd", dm_rdata, 0);
    chk("t4_stall", stall_mem, 0);
    tick;
    mem_rvalid = 0; dm_req = 0; dm_we = 0;
    tick;

    // 5: watchdog abort, then late response
    if_req = 1; if_addr = 32'h500;
    tick;
    chk("t5_req", mem_req, 1);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    for (int c = 1; c < 8; c++) begin
      #1;
      chk($sformatf("t5_rv_w%0d", c), if_rvalid, 0);
      chk($sformatf("t5_to_w%0d", c), err_timeout, 0);
      tick;
    end
    #1;
    chk("t5_rv_w8", if_rvalid, 1);
    chk("t5_rd_w8", if_rdata, 0);
    chk("t5_to_w8", err_timeout, 1);
    tick;
    if_req = 0;
    #1;
    chk("t5_to_after", err_timeout, 0);
    tick;
    mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
    #1;
    chk("t5_spur", err_spurious, 1);
    chk("t5_spur_ifrv", if_rvalid, 0);
    chk("t5_spur_dmrv", dm_rvalid, 0);
    tick;
    mem_rvalid = 0;
    #1;
    chk("t5_spur_off", err_spurious, 0);

    // 6: reset while in WAIT
    dm_req = 1; dm_we = 0; dm_addr = 32'h6000;
    tick;
    chk("t6_req", mem_req, 1);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    reset = 1;
    mem_rvalid = 1; mem_rdata = 32'h66666666;
    #1;
    chk("t6_rst_dmrv", dm_rvalid, 0);
    chk("t6_rst_stall", stall_mem, 1);
    tick;
    reset = 0; mem_rvalid = 0;
    #1;
    chk("t6_post_req", mem_req, 0);
    chk("t6_post_addr", mem_addr, 0);
    tick;
    chk("t6_reissue", mem_req, 1);
    chk("t6_readdr", mem_addr, 32'h6000);
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h77778888;
    #1;
    chk("t6_dmrv", dm_rvalid, 1);
    chk("t6_dmrd", dm_rdata, 32'h77778888);
    chk("t6_spur", err_spurious, 0);
    tick;
    mem_rvalid = 0; dm_req = 0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
